// File: rtl/bridge_plant.sv
// bridge_plant: bascule bridge plant model with deck travel, boat and car FSMs, fault and alarm monitors.
// Ports: Clock, Reset (sync, active-low); MT raise/lower, AL alarm, TFL traffic light,
// boat_req/car_req/fault_inj pulses in; S1 down, S2 fault, S3 up, S4 car on deck,
// S5 boat waiting, S6 boat passing, err_noalarm out. All outputs are flops.
module bridge_plant #(
  parameter int TRAVEL    = 8,
  parameter int BOAT_PASS = 4,
  parameter int CAR_CROSS = 3
) (
  input  logic Clock,
  input  logic Reset,
  input  logic MT,
  input  logic AL,
  input  logic TFL,
  input  logic boat_req,
  input  logic car_req,
  input  logic fault_inj,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic S4,
  output logic S5,
  output logic S6,
  output logic err_noalarm
);
  localparam int PW = $clog2(TRAVEL + 1);
  localparam int BW = BOAT_PASS > 1 ? $clog2(BOAT_PASS) : 1;
  localparam int CW = CAR_CROSS > 1 ? $clog2(CAR_CROSS) : 1;
  localparam logic [PW-1:0] TOP = PW'(TRAVEL);
  localparam logic [BW-1:0] BLAST = BW'(BOAT_PASS - 1);
  localparam logic [CW-1:0] CLAST = CW'(CAR_CROSS - 1);
  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_PASS} boat_t;
  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_CROSS} car_t;
  boat_t boat_q, boat_d;
  car_t car_q, car_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic s1_q, s2_q, s3_q, s4_q, s5_q, s6_q, err_q, al_q;
  logic s2_d, err_d, al_d, inc;
  always_comb begin
    inc    = MT && pos_q != TOP;
    pos_d  = inc ? pos_q + 1'b1 : (!MT && pos_q != '0) ? pos_q - 1'b1 : pos_q;
    boat_d = (boat_q == B_IDLE && boat_req) ? B_WAIT :
             (boat_q == B_WAIT && s3_q) ? B_PASS :
             (boat_q == B_PASS && bcnt_q == BLAST) ? B_IDLE : boat_q;
    bcnt_d = (boat_q == B_PASS && bcnt_q != BLAST) ? bcnt_q + 1'b1 : '0;
    car_d  = (car_q == C_IDLE && car_req) ? C_WAIT :
             (car_q == C_WAIT && !TFL && pos_q == '0) ? C_CROSS :
             (car_q == C_CROSS && ccnt_q == CLAST) ? C_IDLE : car_q;
    ccnt_d = (car_q == C_CROSS && ccnt_q != CLAST) ? ccnt_q + 1'b1 : '0;
    s2_d   = s2_q | fault_inj | (car_q == C_CROSS && inc) | (boat_q == B_PASS && pos_q != TOP);
    // al_q remembers that the previous cycle already had an unanswered fault
    al_d   = s2_q & ~AL;
    err_d  = err_q | (al_q & al_d);
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pos_q  <= '0;
      boat_q <= B_IDLE;
      car_q  <= C_IDLE;
      bcnt_q <= '0;
      ccnt_q <= '0;
      al_q   <= 1'b0;
      err_q  <= 1'b0;
      s1_q   <= 1'b1;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      s4_q   <= 1'b0;
      s5_q   <= 1'b0;
      s6_q   <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      boat_q <= boat_d;
      car_q  <= car_d;
      bcnt_q <= bcnt_d;
      ccnt_q <= ccnt_d;
      al_q   <= al_d;
      err_q  <= err_d;
      s1_q   <= pos_d == '0;
      s2_q   <= s2_d;
      s3_q   <= pos_d == TOP;
      s4_q   <= car_d == C_CROSS;
      s5_q   <= boat_d == B_WAIT;
      s6_q   <= boat_d == B_PASS;
    end
  end
  assign S1 = s1_q;
  assign S2 = s2_q;
  assign S3 = s3_q;
  assign S4 = s4_q;
  assign S5 = s5_q;
  assign S6 = s6_q;
  assign err_noalarm = err_q;
endmodule

// File: tb/tb_bridge_plant.sv
// tb_bridge_plant: directed and randomized checking of bridge_plant against a behavioural model.
module tb_bridge_plant;
  localparam int T = 8, BP = 4, CC = 3;
  logic Clock = 0, Reset = 0, MT = 0, AL = 0, TFL = 0, boat_req = 0, car_req = 0, fault_inj = 0;
  logic S1, S2, S3, S4, S5, S6, err_noalarm;
  int vectors = 0, miscompares = 0;
  int m_pos = 0, m_boat = 0, m_brem = 0, m_car = 0, m_crem = 0, m_run = 0;
  bit m_s2 = 0, m_err = 0;
  always #5 Clock = ~Clock;
  bridge_plant #(.TRAVEL(T), .BOAT_PASS(BP), .CAR_CROSS(CC)) dut (
    .Clock(Clock), .Reset(Reset), .MT(MT), .AL(AL), .TFL(TFL), .boat_req(boat_req),
    .car_req(car_req), .fault_inj(fault_inj), .S1(S1), .S2(S2), .S3(S3), .S4(S4),
    .S5(S5), .S6(S6), .err_noalarm(err_noalarm));
  function automatic logic [6:0] expv();
    return {m_pos == 0, m_s2, m_pos == T, m_car == 2, m_boat == 1, m_boat == 2, m_err};
  endfunction
  function automatic logic [6:0] outs();
    return {S1, S2, S3, S4, S5, S6, err_noalarm};
  endfunction
  task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic lit(string name, logic act, logic exp);
    chk(name, {6'b0, act}, {6'b0, exp});
  endtask
  // Model: boat/car are 0 idle, 1 waiting, 2 busy, with a countdown of remaining busy cycles.
  task automatic model_step();
    bit inc, dec;
    if (!Reset) begin
      m_pos = 0; m_boat = 0; m_brem = 0; m_car = 0; m_crem = 0; m_run = 0; m_s2 = 0; m_err = 0;
      return;
    end
    inc = MT && m_pos < T;
    dec = !MT && m_pos > 0;
    m_run = (m_s2 && !AL) ? m_run + 1 : 0;
    if (m_run >= 2) m_err = 1;
    if (fault_inj || (m_car == 2 && inc) || (m_boat == 2 && m_pos < T)) m_s2 = 1;
    if (m_boat == 0) begin
      if (boat_req) m_boat = 1;
    end else if (m_boat == 1) begin
      if (m_pos == T) begin m_boat = 2; m_brem = BP; end
    end else begin
      m_brem--;
      if (m_brem == 0) m_boat = 0;
    end
    if (m_car == 0) begin
      if (car_req) m_car = 1;
    end else if (m_car == 1) begin
      if (m_pos == 0 && !TFL) begin m_car = 2; m_crem = CC; end
    end else begin
      m_crem--;
      if (m_crem == 0) m_car = 0;
    end
    m_pos = m_pos + int'(inc) - int'(dec);
  endtask
  task automatic step(string name = "model");
    model_step();
    @(posedge Clock);
    @(negedge Clock);
    chk(name, outs(), expv());
  endtask
  initial begin
    step("reset"); step("reset");
    chk("reset_lit", outs(), 7'b1000000);
    Reset = 1;
    repeat (20) begin step("idle"); chk("idle_lit", outs(), 7'b1000000); end
    MT = 1; boat_req = 1; step("rise"); boat_req = 0;
    lit("s1_fall", S1, 0); lit("s5_wait", S5, 1);
    repeat (6) step("rise");
    lit("s3_not_yet", S3, 0);
    step("rise");
    lit("s3_up", S3, 1); lit("s5_still", S5, 1);
    step("pass"); lit("s6_start", S6, 1); lit("s5_clear", S5, 0);
    repeat (3) step("pass");
    lit("s6_last", S6, 1);
    step("pass"); lit("s6_end", S6, 0); lit("s5_end", S5, 0); lit("s2_clean", S2, 0);
    boat_req = 1; step("boat2"); boat_req = 0;
    lit("s5_boat2", S5, 1);
    step("boat2"); lit("s6_boat2", S6, 1);
    Reset = 0; step("rst_pass");
    chk("rst_pass_lit", outs(), 7'b1000000);
    Reset = 1; MT = 0; AL = 0; fault_inj = 1; step("fault"); fault_inj = 0;
    lit("s2_fault", S2, 1); lit("err_early", err_noalarm, 0);
    step("fault"); lit("err_one", err_noalarm, 0);
    step("fault"); lit("err_set", err_noalarm, 1);
    Reset = 0; step("rst"); Reset = 1;
    AL = 1; fault_inj = 1; step("fault_al"); fault_inj = 0;
    repeat (4) step("fault_al");
    lit("err_al", err_noalarm, 0); lit("s2_sticky", S2, 1);
    Reset = 0; step("rst"); Reset = 1; AL = 0;
    car_req = 1; step("car"); car_req = 0;
    lit("s4_wait", S4, 0);
    MT = 1; step("car"); lit("s4_cross", S4, 1); lit("s2_car_pre", S2, 0);
    step("car"); lit("s2_car", S2, 1);
    repeat (3) step("car");
    lit("s2_car_hold", S2, 1); lit("s4_done", S4, 0);
    Reset = 0; step("rst"); Reset = 1; MT = 0;
    for (int i = 0; i < 3000; i++) begin
      Reset = $urandom_range(0, 199) != 0;
      if ($urandom_range(0, 11) == 0) MT = ~MT;
      AL = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) TFL = ~TFL;
      boat_req = $urandom_range(0, 9) == 0;
      car_req = $urandom_range(0, 7) == 0;
      fault_inj = $urandom_range(0, 149) == 0;
      step("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bridge_plant.md
BRIDGE_PLANT -- requirements
Module: bridge_plant

Interface
REQ-001 Parameter TRAVEL, default 8: number of cycles of deck travel between the fully-down and fully-up positions; legal range 2..255.
REQ-002 Parameter BOAT_PASS, default 4: number of cycles a boat occupies the channel.
REQ-003 Parameter CAR_CROSS, default 3: number of cycles a car occupies the deck.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-low; sampled on the rising edge of Clock.
REQ-006 MT  input  1  motor command: 1 = raise the deck, 0 = lower the deck.
REQ-007 AL  input  1  alarm command from the controller.
REQ-008 TFL  input  1  traffic light: 1 = cars stopped, 0 = cars may enter.
REQ-009 boat_req  input  1  one-cycle pulse: a boat arrives.
REQ-010 car_req  input  1  one-cycle pulse: a car arrives.
REQ-011 fault_inj  input  1  one-cycle pulse: force an obstruction fault.
REQ-012 S1  output  1  deck fully down.
REQ-013 S2  output  1  obstruction or fault present (sticky).
REQ-014 S3  output  1  deck fully up.
REQ-015 S4  output  1  car on the deck.
REQ-016 S5  output  1  boat waiting at the bridge.
REQ-017 S6  output  1  boat in the channel under the deck.
REQ-018 err_noalarm  output  1  controller failed to raise the alarm on a fault (sticky).

Function
REQ-019 All outputs shall be registered.
REQ-020 Deck position pos shall range 0..TRAVEL; S1 = (pos==0) and S3 = (pos==TRAVEL).
REQ-021 Deck motion, one step per cycle:
- MT=1 and pos<TRAVEL: pos increments by 1.
- MT=0 and pos>0: pos decrements by 1.
- At the limits pos saturates and never wraps.
REQ-022 The boat FSM shall have three states:
- B_IDLE --boat_req--> B_WAIT.
- B_WAIT --S3==1--> B_PASS.
- B_PASS --after BOAT_PASS cycles--> B_IDLE.
REQ-023 S5=1 exactly in B_WAIT; S6=1 exactly in B_PASS.
REQ-024 boat_req shall be ignored in any state other than B_IDLE.
REQ-025 The car FSM shall have three states:
- C_IDLE --car_req--> C_WAIT.
- C_WAIT --TFL==0 and pos==0--> C_CROSS.
- C_CROSS --after CAR_CROSS cycles--> C_IDLE.
REQ-026 S4=1 exactly in C_CROSS; car_req shall be ignored in any state other than C_IDLE.
REQ-027 A car in C_CROSS shall complete its crossing even if TFL rises during the crossing.
REQ-028 S2 shall be set the cycle after any of the following, and shall remain set until reset:
- fault_inj=1;
- pos increments while the car FSM is in C_CROSS;
- pos is below TRAVEL while the boat FSM is in B_PASS.
REQ-029 err_noalarm shall be set after S2=1 and AL=0 on 2 consecutive cycles, and shall remain set until reset.
REQ-030 Events in the same cycle shall be evaluated independently; boat_req and car_req arriving together shall both be accepted when their FSMs are idle.
REQ-031 The boat-pass counter and the car-cross counter shall be separate and shall each be only as wide as their parameter requires.

Reset
REQ-032 When Reset=0 at a rising edge, the block shall set:
- pos=0, both FSMs to their idle states, all counters to 0;
- outputs S1=1, S2=0, S3=0, S4=0, S5=0, S6=0, err_noalarm=0.
REQ-033 Reset asserted mid-crossing or mid-travel shall abort the activity immediately, with no residual pending request.

Verification
REQ-034 Reset released, MT=0, no requests -> S1=1 and S2..S6=0 held for 20 cycles.
REQ-035 MT=1 held, TRAVEL=8 -> S1 falls 1 cycle after MT rises; S3 rises 8 cycles after MT rises; pos saturates at 8.
REQ-036 boat_req pulse with MT=1 and the deck down -> S5=1 until S3 rises; then S6=1 for exactly 4 cycles; then S5=S6=0.
REQ-037 car_req pulse with TFL=0 and the deck down, followed by MT=1 one cycle later -> S4=1 and S2=1 one cycle after pos first increments; S2 stays 1.
REQ-038 fault_inj pulse with AL=0 -> S2=1 next cycle; err_noalarm=1 two cycles later. Repeating with AL=1 -> err_noalarm stays 0.
REQ-039 Reset pulsed during B_PASS with the deck up -> all outputs equal the REQ-032 reset values on the next cycle.
